latch256_arbiter: RTL and testbench

- Round-robin arbiter sharing one 256-bit holding latch (clk/resetn, enable_i, clear_i, d_i/valid_i, d_o/valid_o) among NUM_REQ producers.
- Grants one producer at a time and drives the latch load strobe and data.
- Presents the held word to a single consumer with a valid/ready handshake, then clears the latch.
- Sits between producer stages and the downstream consumer. Consumer data comes directly from the latch d_o. This block supplies valid, source ID and flow control.

---
 rtl/latch256_arbiter.sv | 171 +++++++++++++++++
 tb/tb_latch256_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch256_arbiter.sv
// Round-robin arbiter that shares one wide holding latch among several
// producers. One producer is granted at a time and its word is loaded into
// the latch. The held word is offered to a single consumer, and the latch is
// cleared after the consumer accepts it or after an optional timeout drop.
module latch256_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 16
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic [NUM_REQ-1:0]                            req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]                     req_data_i,
  output logic [NUM_REQ-1:0]                            req_ready_o,
  output logic [DATA_W-1:0]                             latch_d_o,
  output logic                                          latch_load_o,
  output logic                                          latch_clear_o,
  input  logic                                          latch_valid_i,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] out_src_o,
  output logic [CNT_W-1:0]                              xfer_cnt_o,
  output logic                                          drop_o,
  output logic                                          err_o
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [SRC_W-1:0]   src_reg, src_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               err_reg, err_next;

  // Candidate requester indices in round-robin order, starting just after
  // the last granted requester.
  logic [SRC_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] req_rot;
  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;

  // Partial OR-chain for the one-hot data mux.
  logic [DATA_W-1:0]  mux_chain [NUM_REQ+1];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign cand_idx[gi] = SRC_W'((int'(rr_ptr_reg) + gi + 1) % NUM_REQ);
      assign req_rot[gi]  = req_valid_i[cand_idx[gi]];
    end
  endgenerate

  // Pick the first valid requester in rotated order.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_rot[i]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  // The data mux is driven by the grant vector. latch_d_o is therefore zero
  // whenever nothing is being loaded, including during reset.
  assign mux_chain[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
      assign mux_chain[gi+1] = mux_chain[gi] |
        ({DATA_W{req_ready_o[gi]}} & req_data_i[gi*DATA_W +: DATA_W]);
    end
  endgenerate
  assign latch_d_o = mux_chain[NUM_REQ];

  // Next-state and output logic. Reset overrides the strobes so that the
  // latch is cleared while resetn is low and nothing else is asserted.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    src_next      = src_reg;
    tmo_next      = tmo_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    req_ready_o   = '0;
    latch_load_o  = 1'b0;
    latch_clear_o = 1'b0;
    out_valid_o   = 1'b0;
    drop_o        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          req_ready_o[grant_idx] = 1'b1;
          latch_load_o           = 1'b1;
          rr_ptr_next            = grant_idx;
          src_next               = grant_idx;
          tmo_next               = '0;
          state_next             = HOLD;
        end
      end
      HOLD: begin
        out_valid_o = latch_valid_i;
        if (!latch_valid_i) begin
          err_next = 1'b1;
        end
        if (latch_valid_i && out_ready_i) begin
          // An accept wins over a timeout that falls in the same cycle.
          latch_clear_o = 1'b1;
          cnt_next      = cnt_reg + CNT_W'(1);
          tmo_next      = '0;
          state_next    = IDLE;
        end else if (TIMEOUT_CYC > 0) begin
          if (tmo_reg == TMO_LAST) begin
            latch_clear_o = 1'b1;
            drop_o        = 1'b1;
            tmo_next      = '0;
            state_next    = IDLE;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (!resetn) begin
      req_ready_o   = '0;
      latch_load_o  = 1'b0;
      out_valid_o   = 1'b0;
      drop_o        = 1'b0;
      latch_clear_o = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= LAST_REQ;
      src_reg    <= '0;
      tmo_reg    <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      src_reg    <= src_next;
      tmo_reg    <= tmo_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
    end
  end

  assign out_src_o  = src_reg;
  assign xfer_cnt_o = cnt_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_latch256_arbiter.sv
// Directed bench for latch256_arbiter. Instance u0 has no timeout and
// instance u1 has an 8-cycle timeout. Both instances share stimulus, and each
// one drives its own behavioural model of the holding latch.
module tb_latch256_arbiter;

  logic          clk = 1'b0;
  logic          resetn;
  logic [3:0]    req_valid;
  logic [1023:0] req_data;
  logic          out_ready;
  logic          force_bad;

  logic [255:0]  words [4];

  logic [3:0]    ready0, ready1;
  logic [255:0]  d0, d1;
  logic          load0, load1, clear0, clear1;
  logic          valid0, valid1, drop0, drop1, err0, err1;
  logic [1:0]    src0, src1;
  logic [15:0]   cnt0, cnt1;

  // Latch models and the valid lines as the DUTs see them.
  logic          lv0, lv1;
  logic [255:0]  ld0, ld1;
  logic          lv_in0, lv_in1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign lv_in0 = lv0 & ~force_bad;
  assign lv_in1 = lv1 & ~force_bad;

  latch256_arbiter #(.NUM_REQ(4), .DATA_W(256), .TIMEOUT_CYC(0), .CNT_W(16)) u0 (
    .clk(clk), .resetn(resetn), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(ready0), .latch_d_o(d0), .latch_load_o(load0),
    .latch_clear_o(clear0), .latch_valid_i(lv_in0), .out_valid_o(valid0),
    .out_ready_i(out_ready), .out_src_o(src0), .xfer_cnt_o(cnt0),
    .drop_o(drop0), .err_o(err0)
  );

  latch256_arbiter #(.NUM_REQ(4), .DATA_W(256), .TIMEOUT_CYC(8), .CNT_W(16)) u1 (
    .clk(clk), .resetn(resetn), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(ready1), .latch_d_o(d1), .latch_load_o(load1),
    .latch_clear_o(clear1), .latch_valid_i(lv_in1), .out_valid_o(valid1),
    .out_ready_i(out_ready), .out_src_o(src1), .xfer_cnt_o(cnt1),
    .drop_o(drop1), .err_o(err1)
  );

  // Holding latch behaviour: a clear has priority over a load.
  always @(posedge clk) begin
    if (clear0) begin lv0 <= 1'b0; ld0 <= '0; end
    else if (load0) begin lv0 <= 1'b1; ld0 <= d0; end
    if (clear1) begin lv1 <= 1'b0; ld1 <= '0; end
    else if (load1) begin lv1 <= 1'b1; ld1 <= d1; end
  end

  typedef struct {
    logic        rst_n;
    logic [3:0]  rv;
    logic        ordy;
    logic [3:0]  rdy;
    logic        load;
    logic        clr;
    logic        vld;
    logic [1:0]  src;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rv, input logic ordy,
                     input logic [3:0] rdy, input logic ld, input logic clr,
                     input logic vld, input logic [1:0] src, input logic [15:0] cnt);
    vec_t v;
    v.rst_n = r; v.rv = rv; v.ordy = ordy; v.rdy = rdy; v.load = ld;
    v.clr = clr; v.vld = vld; v.src = src; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Watchdog so that the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    words[0] = {32{8'h11}};
    words[1] = {32{8'h22}};
    words[2] = {32{8'hA5}};
    words[3] = {32{8'h3C}};
    req_data  = {words[3], words[2], words[1], words[0]};
    resetn    = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b0;
    force_bad = 1'b0;

    // Reset, round robin, single transfer, backpressure, reset in HOLD.
    add(0, 4'hF, 0, 4'h0, 0, 1, 0, 0, 0);
    add(0, 4'hF, 0, 4'h0, 0, 1, 0, 0, 0);
    add(1, 4'hF, 1, 4'h1, 1, 0, 0, 0, 0);
    add(1, 4'hF, 1, 4'h0, 0, 1, 1, 0, 0);
    add(1, 4'hF, 1, 4'h2, 1, 0, 0, 0, 1);
    add(1, 4'hF, 1, 4'h0, 0, 1, 1, 1, 1);
    add(1, 4'hF, 1, 4'h4, 1, 0, 0, 1, 2);
    add(1, 4'hF, 1, 4'h0, 0, 1, 1, 2, 2);
    add(1, 4'hF, 1, 4'h8, 1, 0, 0, 2, 3);
    add(1, 4'hF, 1, 4'h0, 0, 1, 1, 3, 3);
    add(1, 4'hF, 1, 4'h1, 1, 0, 0, 3, 4);
    add(1, 4'hF, 1, 4'h0, 0, 1, 1, 0, 4);
    add(1, 4'hF, 1, 4'h2, 1, 0, 0, 0, 5);
    add(1, 4'hF, 1, 4'h0, 0, 1, 1, 1, 5);
    add(1, 4'h4, 1, 4'h4, 1, 0, 0, 1, 6);
    add(1, 4'h0, 1, 4'h0, 0, 1, 1, 2, 6);
    add(1, 4'h0, 0, 4'h0, 0, 0, 0, 2, 7);
    add(1, 4'h8, 0, 4'h8, 1, 0, 0, 2, 7);
    for (int i = 0; i < 10; i++) add(1, 4'hF, 0, 4'h0, 0, 0, 1, 3, 7);
    add(0, 4'hF, 0, 4'h0, 0, 1, 0, 3, 7);
    add(1, 4'hF, 1, 4'h1, 1, 0, 0, 0, 0);
    add(1, 4'hF, 1, 4'h0, 0, 1, 1, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      resetn    = vecs[i].rst_n;
      req_valid = vecs[i].rv;
      out_ready = vecs[i].ordy;
      #1;
      chk("req_ready", 256'(ready0), 256'(vecs[i].rdy));
      chk("latch_load", 256'(load0), 256'(vecs[i].load));
      chk("latch_clear", 256'(clear0), 256'(vecs[i].clr));
      chk("out_valid", 256'(valid0), 256'(vecs[i].vld));
      chk("out_src", 256'(src0), 256'(vecs[i].src));
      chk("xfer_cnt", 256'(cnt0), 256'(vecs[i].cnt));
      chk("err", 256'(err0), 256'(1'b0));
      chk("drop", 256'(drop0), 256'(1'b0));
      chk("latch_d", d0, vecs[i].load ? words[oh_idx(vecs[i].rdy)] : 256'd0);
      if (vecs[i].vld) chk("held_word", ld0, words[vecs[i].src]);
      if (vecs[i].rst_n && !vecs[i].vld) chk("latch_empty", 256'(lv0), 256'(1'b0));
      $display("vec %0d: rst_n=%b rv=%b ordy=%b rdy=%b load=%b clr=%b vld=%b src=%0d cnt=%0d",
               i, resetn, req_valid, out_ready, ready0, load0, clear0, valid0, src0, cnt0);
    end

    // Timeout versus no timeout, driven from a common reset.
    @(negedge clk); resetn = 1'b0; req_valid = 4'h0; out_ready = 1'b0;
    @(negedge clk); resetn = 1'b1; req_valid = 4'b0100;
    #1;
    chk("tmo_grant0", 256'(ready0), 256'(4'b0100));
    chk("tmo_grant1", 256'(ready1), 256'(4'b0100));
    for (int h = 1; h <= 10; h++) begin
      @(negedge clk); req_valid = 4'h0; out_ready = 1'b0;
      #1;
      chk("bp_valid0", 256'(valid0), 256'(1'b1));
      chk("bp_src0", 256'(src0), 256'(2'd2));
      chk("bp_ready0", 256'(ready0), 256'(4'h0));
      chk("bp_drop0", 256'(drop0), 256'(1'b0));
      if (h <= 8) begin
        chk("tmo_drop1", 256'(drop1), 256'(h == 8));
        chk("tmo_clear1", 256'(clear1), 256'(h == 8));
        chk("tmo_valid1", 256'(valid1), 256'(1'b1));
      end else begin
        chk("tmo_idle1", 256'(valid1), 256'(1'b0));
        chk("tmo_latch1", 256'(lv1), 256'(1'b0));
        chk("tmo_cnt1", 256'(cnt1), 256'(16'd0));
      end
      $display("hold %0d: valid0=%b src0=%0d valid1=%b drop1=%b clear1=%b",
               h, valid0, src0, valid1, drop1, clear1);
    end
    @(negedge clk); out_ready = 1'b1;
    #1;
    chk("bp_accept_clear0", 256'(clear0), 256'(1'b1));
    chk("bp_cnt0_before", 256'(cnt0), 256'(16'd0));

    // Accept landing on the timeout cycle: the accept wins.
    @(negedge clk); req_valid = 4'b0001; out_ready = 1'b0;
    #1;
    chk("bp_cnt0_after", 256'(cnt0), 256'(16'd1));
    chk("tie_grant0", 256'(ready0), 256'(4'b0001));
    chk("tie_grant1", 256'(ready1), 256'(4'b0001));
    for (int h = 1; h <= 8; h++) begin
      @(negedge clk); req_valid = 4'h0; out_ready = (h == 8);
      #1;
      chk("tie_valid1", 256'(valid1), 256'(1'b1));
      if (h == 8) begin
        chk("tie_clear1", 256'(clear1), 256'(1'b1));
        chk("tie_drop1", 256'(drop1), 256'(1'b0));
      end
      $display("tie %0d: valid1=%b drop1=%b clear1=%b", h, valid1, drop1, clear1);
    end
    @(negedge clk); out_ready = 1'b0;
    #1;
    chk("tie_cnt1", 256'(cnt1), 256'(16'd1));
    chk("tie_idle1", 256'(valid1), 256'(1'b0));
    chk("tie_cnt0", 256'(cnt0), 256'(16'd2));

    // Protocol error: the latch reports empty during HOLD.
    @(negedge clk); req_valid = 4'b0010; out_ready = 1'b1;
    #1;
    chk("err_grant", 256'(ready0), 256'(4'b0010));
    @(negedge clk); req_valid = 4'h0; force_bad = 1'b1;
    #1;
    chk("err_valid_low", 256'(valid0), 256'(1'b0));
    chk("err_no_clear", 256'(clear0), 256'(1'b0));
    chk("err_not_yet", 256'(err0), 256'(1'b0));
    @(negedge clk); force_bad = 1'b0;
    #1;
    chk("err_set", 256'(err0), 256'(1'b1));
    chk("err_recovered_valid", 256'(valid0), 256'(1'b1));
    chk("err_accept_clear", 256'(clear0), 256'(1'b1));
    for (int h = 0; h < 3; h++) begin
      @(negedge clk); out_ready = 1'b0;
      #1;
      chk("err_sticky", 256'(err0), 256'(1'b1));
      $display("err hold %0d: err0=%b valid0=%b", h, err0, valid0);
    end
    @(negedge clk); resetn = 1'b0;
    #1;
    chk("err_in_reset", 256'(err0), 256'(1'b1));
    chk("reset_clear", 256'(clear0), 256'(1'b1));
    @(negedge clk); resetn = 1'b1;
    #1;
    chk("err_cleared", 256'(err0), 256'(1'b0));
    chk("reset_cnt", 256'(cnt0), 256'(16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
